// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller signal bundle: pipeline register fields in, stall/flush/forward controls out.
interface pipeline_hazard_ctrl_if;
  logic [4:0]  id_rs1, id_rs2;
  logic        id_uses_rs2;
  logic [4:0]  idex_rs1, idex_rs2, idex_rd;
  logic        idex_mem_read, idex_reg_write;
  logic [4:0]  exmem_rd;
  logic        exmem_reg_write;
  logic [4:0]  memwb_rd;
  logic        memwb_reg_write;
  logic        branch_taken, ex_busy, cnt_clear;
  logic        pc_write, ifid_write, idex_bubble;
  logic        ifid_flush, idex_flush, exmem_flush;
  logic [1:0]  forward_a, forward_b;
  logic [15:0] stall_cycles, flush_events;

  // pipeline side: supplies fields, consumes controls
  modport master (
    output id_rs1, id_rs2, id_uses_rs2, idex_rs1, idex_rs2, idex_rd,
           idex_mem_read, idex_reg_write, exmem_rd, exmem_reg_write,
           memwb_rd, memwb_reg_write, branch_taken, ex_busy, cnt_clear,
    input  pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush,
           exmem_flush, forward_a, forward_b, stall_cycles, flush_events
  );

  // controller side
  modport slave (
    input  id_rs1, id_rs2, id_uses_rs2, idex_rs1, idex_rs2, idex_rd,
           idex_mem_read, idex_reg_write, exmem_rd, exmem_reg_write,
           memwb_rd, memwb_reg_write, branch_taken, ex_busy, cnt_clear,
    output pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush,
           exmem_flush, forward_a, forward_b, stall_cycles, flush_events
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage pipeline hazard controller: load-use stall, multi-cycle EX hold,
// branch flush, operand forwarding and saturating stall/flush statistics.
module pipeline_hazard_ctrl (
  input  logic                    clk,
  input  logic                    reset,
  pipeline_hazard_ctrl_if.slave   hz
);

  typedef enum logic [1:0] {RUN, LU_STALL, BUSY, FLUSH} state_t;

  state_t      state, state_nxt;
  logic        lu, lu_live;
  logic        pc_write, ifid_write, idex_bubble, flush_all;
  logic [15:0] stall_cycles, flush_events;

  assign lu = hz.idex_mem_read && (hz.idex_rd != 5'd0) &&
              ((hz.idex_rd == hz.id_rs1) ||
               (hz.id_uses_rs2 && (hz.idex_rd == hz.id_rs2)));

  // After a flush IF/ID holds a bubble, and after a load-use stall the load
  // has already moved on; either way the comparison would be stale.
  assign lu_live = lu && (state != FLUSH) && (state != LU_STALL);

  // State register; reset aborts any stall or flush in progress
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // Event priority branch > busy > load-use, same decision from every state
  always_comb begin
    state_nxt   = RUN;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    flush_all   = 1'b0;
    if (reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      flush_all   = 1'b1;
    end else if (hz.branch_taken) begin
      flush_all = 1'b1;
      state_nxt = FLUSH;
    end else if (hz.ex_busy) begin
      // ID/EX must keep the instruction waiting on EX, so no bubble
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      state_nxt  = BUSY;
    end else if (lu_live) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      state_nxt   = LU_STALL;
    end
  end

  // Forwarding: the younger result in EX/MEM wins over MEM/WB; x0 never forwards
  always_comb begin
    hz.forward_a = 2'b00;
    hz.forward_b = 2'b00;
    if (!reset) begin
      if (hz.exmem_reg_write && hz.exmem_rd != 5'd0 && hz.exmem_rd == hz.idex_rs1)
        hz.forward_a = 2'b10;
      else if (hz.memwb_reg_write && hz.memwb_rd != 5'd0 && hz.memwb_rd == hz.idex_rs1)
        hz.forward_a = 2'b01;
      if (hz.exmem_reg_write && hz.exmem_rd != 5'd0 && hz.exmem_rd == hz.idex_rs2)
        hz.forward_b = 2'b10;
      else if (hz.memwb_reg_write && hz.memwb_rd != 5'd0 && hz.memwb_rd == hz.idex_rs2)
        hz.forward_b = 2'b01;
    end
  end

  // Saturating statistics; clear wins over increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= 16'd0;
      flush_events <= 16'd0;
    end else if (hz.cnt_clear) begin
      stall_cycles <= 16'd0;
      flush_events <= 16'd0;
    end else begin
      if (!pc_write && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
      if (hz.branch_taken && flush_events != 16'hFFFF)
        flush_events <= flush_events + 16'd1;
    end
  end

  assign hz.pc_write     = pc_write;
  assign hz.ifid_write   = ifid_write;
  assign hz.idex_bubble  = idex_bubble;
  assign hz.ifid_flush   = flush_all;
  assign hz.idex_flush   = flush_all;
  assign hz.exmem_flush  = flush_all;
  assign hz.stall_cycles = stall_cycles;
  assign hz.flush_events = flush_events;

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL clock on clk, 1 bit, input: single rising-edge clock; no other clock is used.
REQ-002 SHALL use reset, 1 bit, input: asynchronous, active-high.
REQ-003 SHALL take id_rs1, id_rs2, 5 bits each, input: source registers of the instruction in IF/ID.
REQ-004 SHALL take id_uses_rs2, 1 bit, input: 1 if the IF/ID instruction reads rs2.
REQ-005 SHALL take idex_rs1, idex_rs2, idex_rd, 5 bits each, input: register fields held in ID/EX.
REQ-006 SHALL take idex_mem_read and idex_reg_write, 1 bit each, input: ID/EX control bits.
REQ-007 SHALL take exmem_rd (5 bits) and exmem_reg_write (1 bit), input: EX/MEM destination fields.
REQ-008 SHALL take memwb_rd (5 bits) and memwb_reg_write (1 bit), input: MEM/WB destination fields.
REQ-009 SHALL take branch_taken, 1 bit, input: Branch AND Zero resolved in the MEM stage.
REQ-010 SHALL take ex_busy, 1 bit, input: multi-cycle EX operation still in progress.
REQ-011 SHALL take cnt_clear, 1 bit, input: synchronous clear of both counters.
REQ-012 SHALL drive pc_write and ifid_write, 1 bit each, output: enables for PC and IF/ID.
REQ-013 SHALL drive idex_bubble, 1 bit, output: zero ID/EX control bits on the next edge.
REQ-014 SHALL drive ifid_flush, idex_flush and exmem_flush, 1 bit each, output: squash those registers.
REQ-015 SHALL drive forward_a and forward_b, 2 bits each, output: ALU operand selects; 00 = register file, 10 = EX/MEM, 01 = MEM/WB.
REQ-016 SHALL drive stall_cycles and flush_events, 16 bits each, output: saturating statistics counters.

Function
REQ-017 SHALL implement FSM states RUN, LU_STALL, BUSY and FLUSH; control outputs are combinational from state and inputs.
REQ-018 SHALL define load-use (lu) as idex_mem_read && idex_rd!=0 && (idex_rd==id_rs1 || (id_uses_rs2 && idex_rd==id_rs2)).
REQ-019 SHALL apply event priority branch_taken > ex_busy > lu, evaluated in every state.
REQ-020 On branch_taken, SHALL assert all three flushes and pc_write=1 in that cycle, with next state FLUSH.
REQ-021 In FLUSH, SHALL suppress lu for exactly one cycle because IF/ID holds a bubble; if no other event, next state is RUN.
REQ-022 On ex_busy without branch_taken, SHALL drive pc_write=0, ifid_write=0 and idex_bubble=0 (ID/EX holds its value), with next state BUSY.
REQ-023 BUSY SHALL persist while ex_busy=1; the first cycle with ex_busy=0 re-evaluates lu normally.
REQ-024 On lu with no higher-priority event, SHALL drive pc_write=0, ifid_write=0 and idex_bubble=1 for exactly one cycle, with next state LU_STALL.
REQ-025 LU_STALL SHALL not re-detect the same load; outputs are normal and the next state is RUN.
REQ-026 In all other cases, SHALL drive pc_write=1, ifid_write=1 and every bubble and flush output 0.
REQ-027 forward_a SHALL be 10 if exmem_reg_write && exmem_rd!=0 && exmem_rd==idex_rs1; else 01 if memwb_reg_write && memwb_rd!=0 && memwb_rd==idex_rs1; else 00.
REQ-028 forward_b SHALL follow the same rule as forward_a using idex_rs2.
REQ-029 stall_cycles SHALL increment on each clock edge where pc_write=0 and reset is low.
REQ-030 flush_events SHALL increment on each edge where branch_taken=1.
REQ-031 Both counters SHALL saturate at 0xFFFF without wrapping.
REQ-032 cnt_clear SHALL zero both counters on the next edge and take priority over an increment in the same cycle; it does not affect the FSM.

Reset
REQ-033 While reset=1, SHALL force state RUN and both counters to 0 immediately, without waiting for clk.
REQ-034 While reset=1, SHALL drive pc_write=0, ifid_write=0, idex_bubble=1, all flushes=1 and forward_a=forward_b=00.
REQ-035 Reset asserted mid-stall or mid-flush SHALL abort that sequence; after release the block starts in RUN with no pending stall.

Verification
REQ-036 Load-use: idex_mem_read=1, idex_rd=5, id_rs1=5 -> one cycle of pc_write=0 and idex_bubble=1, then normal operation; stall_cycles=1.
REQ-037 x0 guard: idex_rd=0 with id_rs1=0 and a load -> no stall; exmem_rd=0 with exmem_reg_write=1 -> forward_a=00.
REQ-038 Double forward: exmem_rd=memwb_rd=7, both writing, idex_rs2=7 -> forward_b=10 (EX/MEM wins).
REQ-039 Branch during lu: branch_taken=1 and lu in the same cycle -> all flushes=1, pc_write=1, no bubble; next cycle lu is ignored; flush_events=1.
REQ-040 ex_busy held 3 cycles then dropped -> pc_write=0 for exactly 3 cycles, ID/EX held; stall_cycles=3.
REQ-041 Saturation and reset: preload via 65535 stalls -> stall_cycles stays 0xFFFF; asynchronous reset pulse between edges -> counters read 0 before the next edge.
